// File: rtl/pl_trace_pkg.sv
// Shared types and record layout for the pipeline trace buffer.
// Record layout, MSB to LSB: {cycle, pc, instr, rd, wdata}.
package pl_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        POSTCAP = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic MODE_STOP = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam int INSTR_W   = 32;
    localparam int RD_W      = 5;
    localparam int WDATA_LSB = 0;

    function automatic int rd_lsb(input int xlen);
        return xlen;
    endfunction

    function automatic int instr_lsb(input int xlen);
        return xlen + RD_W;
    endfunction

    function automatic int pc_lsb(input int xlen);
        return xlen + RD_W + INSTR_W;
    endfunction

    function automatic int cyc_lsb(input int xlen, input int aw);
        return pc_lsb(xlen) + aw;
    endfunction

    function automatic int rec_w(input int xlen, input int aw, input int cw);
        return cyc_lsb(xlen, aw) + cw;
    endfunction

endpackage

// File: rtl/pl_trace_buffer_if.sv
// Readout port of the trace buffer: valid/ready stream of whole records.
interface pl_trace_buffer_if #(
    parameter int RW = 117
);
    logic          rd_valid_o;
    logic          rd_ready_i;
    logic [RW-1:0] rd_data_o;

    modport master (output rd_valid_o, output rd_data_o, input rd_ready_i);
    modport slave  (input rd_valid_o, input rd_data_o, output rd_ready_i);
endinterface

// File: rtl/pl_trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port,
// no reset so it maps onto distributed RAM.
module pl_trace_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 117
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pl_trace_buffer.sv
// Writeback trace capture with arm/trigger/post-trigger control and oldest-first drain.
// Optional PC range filter enabled by defining PLTRACE_PCFILT_EN.
module pl_trace_buffer
    import pl_trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int AW    = 32,
    parameter int DEPTH = 16,
    parameter int CW    = 16,
    parameter int POST  = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   trig_arm_i,
    input  logic                   mode_i,
    input  logic [AW-1:0]          trig_pc_i,
    input  logic [AW-1:0]          pc_i,
    input  logic [31:0]            instr_i,
    input  logic                   rf_wr_i,
    input  logic [4:0]             rf_a3_i,
    input  logic [XLEN-1:0]        rf_wd_i,
`ifdef PLTRACE_PCFILT_EN
    input  logic [AW-1:0]          filt_lo_i,
    input  logic [AW-1:0]          filt_hi_i,
`endif
    pl_trace_buffer_if.master      rd,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic                   triggered_o,
    output logic                   done_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PST_W = (POST > 0) ? $clog2(POST + 1) : 1;
    localparam int RW    = rec_w(XLEN, AW, CW);

    state_e           state_q;
    logic             mode_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CW-1:0]    cyc_q;
    logic [PST_W-1:0] post_q;
    logic             ovf_q, trig_q;

    logic          in_range, ev, capturing, full, wr_en, pop, pc_hit;
    logic [RW-1:0] wr_rec, rd_rec;

`ifdef PLTRACE_PCFILT_EN
    assign in_range = (pc_i >= filt_lo_i) && (pc_i <= filt_hi_i);
`else
    assign in_range = 1'b1;
`endif

    assign ev        = rf_wr_i && (rf_a3_i != 5'd0) && in_range;
    assign capturing = (state_q == CAPTURE) || (state_q == POSTCAP);
    assign full      = (count_q == CNT_W'(DEPTH));
    // When full in wrap mode the write lands on the oldest slot, which rd_ptr then skips.
    assign wr_en     = capturing && ev && !(full && (mode_q == MODE_STOP));
    assign pop       = (state_q == DONE) && (count_q != '0) && rd.rd_ready_i;
    assign pc_hit    = (state_q == CAPTURE) && (pc_i == trig_pc_i);
    assign wr_rec    = {cyc_q, pc_i, instr_i, rf_a3_i, rf_wd_i};

    pl_trace_ram #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_rec),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_rec)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            mode_q   <= MODE_STOP;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cyc_q    <= '0;
            post_q   <= '0;
            ovf_q    <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (trig_arm_i) begin
                        state_q  <= CAPTURE;
                        mode_q   <= mode_i;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        count_q  <= '0;
                        post_q   <= '0;
                        ovf_q    <= 1'b0;
                        trig_q   <= 1'b0;
                    end
                end
                CAPTURE, POSTCAP: begin
                    if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (ev) begin
                        if (!full) begin
                            count_q <= count_q + 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                            if (mode_q == MODE_WRAP) rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                    // The event on the trigger cycle is captured but not counted as post-trigger.
                    if (pc_hit) begin
                        trig_q <= 1'b1;
                        if (POST == 0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= POSTCAP;
                            post_q  <= PST_W'(POST);
                        end
                    end
                    if ((state_q == POSTCAP) && ev) begin
                        post_q <= post_q - 1'b1;
                        if (post_q == PST_W'(1)) state_q <= DONE;
                    end
                end
                DONE: begin
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        count_q  <= count_q - 1'b1;
                        if (count_q == CNT_W'(1)) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd.rd_valid_o = (state_q == DONE) && (count_q != '0);
    assign rd.rd_data_o  = (count_q == '0) ? '0 : rd_rec;
    assign count_o       = count_q;
    assign overflow_o    = ovf_q;
    assign triggered_o   = trig_q;
    assign done_o        = (state_q == DONE);
endmodule

// File: tb/tb_pl_trace_buffer.sv
// Scoreboard bench for pl_trace_buffer: two instances (POST=0 and POST=2) share stimulus,
// sel routes arm/ready to one of them and selects which outputs are observed.
module tb_pl_trace_buffer;
    localparam int XLEN  = 32;
    localparam int AW    = 32;
    localparam int CW    = 16;
    localparam int DEPTH = 16;
    localparam int RW    = CW + AW + 37 + XLEN;
    localparam logic [AW-1:0] TRIG_PC = 32'h0000_0040;
    localparam logic [AW-1:0] PC_IDLE = 32'h0000_2000;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            arm = 1'b0;
    logic            mode = 1'b0;
    logic [AW-1:0]   pc = PC_IDLE;
    logic [31:0]     instr = '0;
    logic            rf_wr = 1'b0;
    logic [4:0]      a3 = '0;
    logic [XLEN-1:0] wd = '0;
    logic            ready = 1'b0;
    logic [AW-1:0]   flo = '0;
    logic [AW-1:0]   fhi = '1;
    int              sel = 0;
    bit              model_wrap = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [RW-1:0] exp_q[$];
    logic [CW-1:0] tcyc;

    logic [4:0] cnt0, cnt2;
    logic       ovf0, ovf2, trg0, trg2, dn0, dn2, arm0, arm2;

    pl_trace_buffer_if #(.RW(RW)) if0 ();
    pl_trace_buffer_if #(.RW(RW)) if2 ();

    assign arm0 = arm && (sel == 0);
    assign arm2 = arm && (sel == 2);
    assign if0.rd_ready_i = ready && (sel == 0);
    assign if2.rd_ready_i = ready && (sel == 2);

    pl_trace_buffer #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .CW(CW), .POST(0)) dut0 (
        .clk(clk), .rstn(rstn), .trig_arm_i(arm0), .mode_i(mode), .trig_pc_i(TRIG_PC),
        .pc_i(pc), .instr_i(instr), .rf_wr_i(rf_wr), .rf_a3_i(a3), .rf_wd_i(wd),
`ifdef PLTRACE_PCFILT_EN
        .filt_lo_i(flo), .filt_hi_i(fhi),
`endif
        .rd(if0.master), .count_o(cnt0), .overflow_o(ovf0), .triggered_o(trg0), .done_o(dn0)
    );

    pl_trace_buffer #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH), .CW(CW), .POST(2)) dut2 (
        .clk(clk), .rstn(rstn), .trig_arm_i(arm2), .mode_i(mode), .trig_pc_i(TRIG_PC),
        .pc_i(pc), .instr_i(instr), .rf_wr_i(rf_wr), .rf_a3_i(a3), .rf_wd_i(wd),
`ifdef PLTRACE_PCFILT_EN
        .filt_lo_i(flo), .filt_hi_i(fhi),
`endif
        .rd(if2.master), .count_o(cnt2), .overflow_o(ovf2), .triggered_o(trg2), .done_o(dn2)
    );

    wire          v   = (sel == 2) ? if2.rd_valid_o : if0.rd_valid_o;
    wire [RW-1:0] d   = (sel == 2) ? if2.rd_data_o  : if0.rd_data_o;
    wire [4:0]    cnt = (sel == 2) ? cnt2 : cnt0;
    wire          ovf = (sel == 2) ? ovf2 : ovf0;
    wire          trg = (sel == 2) ? trg2 : trg0;
    wire          dn  = (sel == 2) ? dn2  : dn0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rstn) tcyc <= '0;
        else       tcyc <= tcyc + 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_cap(input logic m);
        arm = 1'b1;
        mode = m;
        model_wrap = m;
        step();
        arm = 1'b0;
    endtask

    task automatic ev_drive(input logic [AW-1:0] p, input logic [4:0] r,
                            input logic [XLEN-1:0] w, input logic we, input bit keep);
        pc = p; a3 = r; wd = w; rf_wr = we;
        instr = {w[15:0], 16'h0013};
        if (keep) begin
            if (model_wrap && exp_q.size() == DEPTH) void'(exp_q.pop_front());
            exp_q.push_back({tcyc, p, instr, r, w});
        end
        step();
        rf_wr = 1'b0;
        pc = PC_IDLE;
    endtask

    task automatic read_out(input string tag, input int n_exp, input logic [4:0] pat);
        int pops = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic [RW-1:0] held = '0;
        logic [RW-1:0] want;
        while (pops < n_exp && cyc < 64) begin
            ready = (cyc < 5) ? pat[cyc] : 1'b1;
            if (stalled) begin
                n_cmp++;
                if (d !== held) begin n_err++; $display("FAIL %s_stall_stable: got %h want %h", tag, d, held); end
            end
            if (v && ready) begin
                want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                n_cmp++;
                if (d !== want) begin n_err++; $display("FAIL %s_pop%0d: got %h want %h", tag, pops, d, want); end
                pops++;
            end
            stalled = v && !ready;
            held = d;
            step();
            cyc++;
        end
        ready = 1'b0;
        n_cmp++;
        if (pops != n_exp) begin n_err++; $display("FAIL %s_pop_count: got %0d want %0d", tag, pops, n_exp); end
        n_cmp++;
        if (v !== 1'b0) begin n_err++; $display("FAIL %s_valid_after: got %b want 0", tag, v); end
        n_cmp++;
        if (dn !== 1'b0) begin n_err++; $display("FAIL %s_idle_after: got done=%b want 0", tag, dn); end
    endtask

    task automatic test_reset();
        sel = 0;
        rstn = 1'b0;
        step(); step();
        rstn = 1'b1;
        n_cmp++; if (cnt !== 5'd0)   begin n_err++; $display("FAIL reset_count: got %0d want 0", cnt); end
        n_cmp++; if (v !== 1'b0)     begin n_err++; $display("FAIL reset_valid: got %b want 0", v); end
        n_cmp++; if ({dn, ovf, trg} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {dn, ovf, trg}); end
        n_cmp++; if (d !== '0)       begin n_err++; $display("FAIL reset_data: got %h want 0", d); end
    endtask

    task automatic test_non_events();
        sel = 0;
        for (int i = 0; i < 5; i++) ev_drive(32'h100 + 4 * i, (i % 2) ? 5'd3 : 5'd0, 32'hA0 + i, (i % 2) ? 1'b0 : 1'b1, 1'b0);
        n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL idle_count: got %0d want 0", cnt); end
        n_cmp++; if (dn !== 1'b0 || v !== 1'b0) begin n_err++; $display("FAIL idle_state: got done=%b valid=%b want 0 0", dn, v); end
        sel = 2;
        arm_cap(1'b0);
        for (int i = 0; i < 5; i++) ev_drive(32'h100 + 4 * i, (i % 2) ? 5'd3 : 5'd0, 32'hB0 + i, (i % 2) ? 1'b0 : 1'b1, 1'b0);
        n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL x0_capture_count: got %0d want 0", cnt); end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_mode_stop();
        sel = 0;
        exp_q.delete();
        arm_cap(1'b0);
        for (int i = 1; i <= 20; i++) ev_drive(32'h1000 + 4 * i, 5'd5, i, 1'b1, (i <= 16));
        n_cmp++; if (cnt !== 5'd16) begin n_err++; $display("FAIL stop_count_full: got %0d want 16", cnt); end
        pc = TRIG_PC;
        step();
        pc = PC_IDLE;
        n_cmp++; if ({dn, trg, ovf, v} !== 4'b1111) begin n_err++; $display("FAIL stop_flags: got %b want 1111", {dn, trg, ovf, v}); end
        read_out("stop", 16, 5'b11111);
        n_cmp++; if ({ovf, trg} !== 2'b11) begin n_err++; $display("FAIL stop_sticky: got %b want 11", {ovf, trg}); end
    endtask

    task automatic test_mode_wrap();
        sel = 0;
        exp_q.delete();
        arm_cap(1'b1);
        n_cmp++; if ({ovf, trg} !== 2'b00) begin n_err++; $display("FAIL arm_clears_flags: got %b want 00", {ovf, trg}); end
        for (int i = 1; i <= 20; i++) ev_drive(32'h1000 + 4 * i, 5'd5, i, 1'b1, 1'b1);
        pc = TRIG_PC;
        step();
        pc = PC_IDLE;
        n_cmp++; if (cnt !== 5'd16) begin n_err++; $display("FAIL wrap_count: got %0d want 16", cnt); end
        n_cmp++; if ({dn, ovf} !== 2'b11) begin n_err++; $display("FAIL wrap_flags: got %b want 11", {dn, ovf}); end
        read_out("wrap", 16, 5'b11111);
    endtask

    task automatic test_post_trigger();
        sel = 2;
        exp_q.delete();
        arm_cap(1'b0);
        for (int i = 0; i < 3; i++) ev_drive(32'h100 + 4 * i, 5'd7, 32'h30 + i, 1'b1, 1'b1);
        ev_drive(TRIG_PC, 5'd7, 32'h33, 1'b1, 1'b1);
        n_cmp++; if ({trg, dn} !== 2'b10 || cnt !== 5'd4) begin n_err++; $display("FAIL post_trigger: got trg/done=%b count=%0d want 10 4", {trg, dn}, cnt); end
        ev_drive(32'h110, 5'd8, 32'h34, 1'b1, 1'b1);
        n_cmp++; if (dn !== 1'b0 || cnt !== 5'd5) begin n_err++; $display("FAIL post_first: got done=%b count=%0d want 0 5", dn, cnt); end
        ev_drive(32'h114, 5'd9, 32'h35, 1'b1, 1'b1);
        n_cmp++; if (dn !== 1'b1 || cnt !== 5'd6) begin n_err++; $display("FAIL post_second: got done=%b count=%0d want 1 6", dn, cnt); end
        ev_drive(32'h118, 5'd10, 32'h36, 1'b1, 1'b0);
        ev_drive(TRIG_PC, 5'd11, 32'h37, 1'b1, 1'b0);
        n_cmp++; if (cnt !== 5'd6 || dn !== 1'b1) begin n_err++; $display("FAIL post_after_done: got count=%0d done=%b want 6 1", cnt, dn); end
        read_out("post", 6, 5'b11111);
    endtask

    task automatic test_stall_readout();
        sel = 2;
        exp_q.delete();
        arm_cap(1'b0);
        ev_drive(32'h200, 5'd1, 32'hDEAD_0001, 1'b1, 1'b1);
        ev_drive(TRIG_PC, 5'd2, 32'hDEAD_0002, 1'b1, 1'b1);
        ev_drive(32'h204, 5'd3, 32'hDEAD_0003, 1'b1, 1'b1);
        ev_drive(32'h208, 5'd4, 32'hDEAD_0004, 1'b1, 1'b1);
        n_cmp++; if (dn !== 1'b1 || cnt !== 5'd4) begin n_err++; $display("FAIL stall_setup: got done=%b count=%0d want 1 4", dn, cnt); end
        read_out("stall", 4, 5'b11101);
        n_cmp++; if (cnt !== 5'd0 || trg !== 1'b1) begin n_err++; $display("FAIL stall_final: got count=%0d trg=%b want 0 1", cnt, trg); end
    endtask

    task automatic test_reset_midrun();
        sel = 2;
        exp_q.delete();
        arm_cap(1'b0);
        for (int i = 0; i < 6; i++) ev_drive(32'h300 + 4 * i, 5'd12, 32'h60 + i, 1'b1, 1'b0);
        ev_drive(TRIG_PC, 5'd12, 32'h66, 1'b1, 1'b0);
        n_cmp++; if (cnt !== 5'd7 || trg !== 1'b1 || dn !== 1'b0) begin n_err++; $display("FAIL midrun_setup: got count=%0d trg=%b done=%b want 7 1 0", cnt, trg, dn); end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        n_cmp++; if (cnt !== 5'd0) begin n_err++; $display("FAIL midrun_count: got %0d want 0", cnt); end
        n_cmp++; if ({dn, ovf, trg, v} !== 4'b0000) begin n_err++; $display("FAIL midrun_flags: got %b want 0000", {dn, ovf, trg, v}); end
    endtask

`ifdef PLTRACE_PCFILT_EN
    task automatic test_pc_filter();
        sel = 2;
        exp_q.delete();
        flo = 32'h100;
        fhi = 32'h1FF;
        arm_cap(1'b0);
        ev_drive(32'h180, 5'd6, 32'h71, 1'b1, 1'b1);
        ev_drive(32'h200, 5'd6, 32'h72, 1'b1, 1'b0);
        n_cmp++; if (cnt !== 5'd1) begin n_err++; $display("FAIL filt_out_of_range: got %0d want 1", cnt); end
        pc = TRIG_PC;
        step();
        pc = PC_IDLE;
        ev_drive(32'h300, 5'd6, 32'h73, 1'b1, 1'b0);
        n_cmp++; if (dn !== 1'b0 || ovf !== 1'b0) begin n_err++; $display("FAIL filt_post_uncounted: got done=%b ovf=%b want 0 0", dn, ovf); end
        ev_drive(32'h1F0, 5'd6, 32'h74, 1'b1, 1'b1);
        ev_drive(32'h100, 5'd6, 32'h75, 1'b1, 1'b1);
        n_cmp++; if (dn !== 1'b1 || cnt !== 5'd3) begin n_err++; $display("FAIL filt_done: got done=%b count=%0d want 1 3", dn, cnt); end
        read_out("filt", 3, 5'b11111);
        flo = '0;
        fhi = '1;
    endtask
`endif

    initial begin
        test_reset();
        test_non_events();
        test_mode_stop();
        test_mode_wrap();
        test_post_trigger();
        test_stall_readout();
        test_reset_midrun();
`ifdef PLTRACE_PCFILT_EN
        test_pc_filter();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
